price_window_feeder: RTL and testbench
======================================

PRICE_WINDOW_FEEDER -- requirements
Module: price_window_feeder

Interface
REQ-001 Parameters, one per line:
- WINDOW, default 10, number of prices in the averaging window (legal range 2..64).
- DATA_W, default 32, price width in bits.
REQ-002 Ports, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- price_in  in  DATA_W  incoming price sample.
- price_valid  in  1  price_in is valid.
- price_ready  out  1  block can accept a price.
- ma_start  out  1  one-cycle start pulse to the averaging engine.
- ma_new_price  out  DATA_W  newest price presented to the engine.
- ma_oldest_price  out  DATA_W  price leaving the window presented to the engine.
- ma_avg  in  DATA_W  average returned by the engine.
- ma_done  in  1  engine completion pulse.
- avg_out  out  DATA_W  last captured average.
- avg_valid  out  1  one-cycle pulse; avg_out updated.
- window_full  out  1  WINDOW prices have been accepted since reset.
- timeout_err  out  1  sticky engine-timeout flag (see Configuration).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 The block SHALL hold a WINDOW-entry circular buffer of DATA_W prices, a write pointer wr_ptr, and a fill count cnt that saturates at WINDOW.
REQ-005 The FSM SHALL have three states:
- IDLE: price_ready=1.
- ISSUE: ma_start=1 for exactly one cycle.
- WAIT: waits for ma_done.
REQ-006 Acceptance SHALL occur on a rising edge in IDLE with price_valid=1. On that edge:
- ma_new_price <= price_in.
- ma_oldest_price <= buf[wr_ptr] if cnt==WINDOW, else 0.
- buf[wr_ptr] <= price_in.
- wr_ptr advances, wrapping from WINDOW-1 to 0.
- cnt increments unless already at WINDOW.
- The FSM moves to ISSUE.
REQ-007 ma_start SHALL be high in the cycle after acceptance only. ma_new_price and ma_oldest_price SHALL stay stable from that cycle until the next acceptance.
REQ-008 ISSUE SHALL always go to WAIT after one cycle. ma_done sampled in IDLE or ISSUE SHALL be ignored.
REQ-009 In WAIT, ma_done=1 SHALL cause the following on that edge:
- avg_out <= ma_avg.
- avg_valid high for the next cycle only.
- The FSM returns to IDLE.
REQ-010 price_ready SHALL be 0 in ISSUE and WAIT. At most one engine transaction SHALL be outstanding.
REQ-011 window_full SHALL equal (cnt==WINDOW) and be registered. It first goes high in the cycle after the WINDOW-th acceptance.
REQ-012 If price_valid and ma_done are high together in WAIT, only ma_done SHALL be acted on. The price is accepted later from IDLE.

Reset
REQ-013 While rst=1, on each rising edge the block SHALL clear the following to 0: FSM (IDLE), wr_ptr, cnt, ma_start, ma_new_price, ma_oldest_price, avg_out, avg_valid, window_full, timeout_err.
REQ-014 Buffer contents need not be cleared; cnt gating (REQ-006) guarantees stale entries are never presented.
REQ-015 Reset asserted in ISSUE or WAIT SHALL abort the transaction: no avg_valid pulse, and a ma_done arriving afterwards is ignored.

Configuration
REQ-016 Macro PRICE_FEEDER_TIMEOUT_EN SHALL control a watchdog.
- Defined: a 5-bit counter runs in WAIT. If ma_done has not arrived by the 16th WAIT cycle, the FSM returns to IDLE, sets timeout_err (sticky until rst), and does not pulse avg_valid.
- Undefined: WAIT persists until ma_done, and timeout_err is tied to 0.

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- Scenario 1, reset values: assert rst 2 cycles, release -> all outputs 0, price_ready=1, FSM in IDLE.
- Scenario 2, first sample: price_in=100 with price_valid for 1 cycle -> next cycle ma_start=1, ma_new_price=100, ma_oldest_price=0, price_ready=0.
- Scenario 3, wrap-around: accept prices 1..10, engine answering each -> window_full=1 after the 10th. Then accept 11 -> ma_new_price=11, ma_oldest_price=1. Then accept 12 -> ma_oldest_price=2.
- Scenario 4, completion: in WAIT drive ma_avg=55 with ma_done for 1 cycle, price_valid held high -> avg_out=55, avg_valid high exactly 1 cycle, then acceptance from IDLE.
- Scenario 5, reset mid-operation: rst pulsed in WAIT after 3 accepted prices, then ma_done -> no avg_valid, cnt=0, next price gives ma_oldest_price=0.
- Scenario 6, timeout: with PRICE_FEEDER_TIMEOUT_EN, withhold ma_done 20 cycles -> timeout_err=1 after 16 WAIT cycles, price_ready=1. Without the macro -> still in WAIT, timeout_err=0.

Source files
------------

// File: rtl/price_window_feeder.sv
// Feeds a moving-average engine: keeps a WINDOW-deep price ring, issues one
// transaction per accepted price. Optional watchdog: PRICE_FEEDER_TIMEOUT_EN.
module price_window_feeder #(
  parameter int WINDOW = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] price_in,
  input  logic              price_valid,
  output logic              price_ready,
  output logic              ma_start,
  output logic [DATA_W-1:0] ma_new_price,
  output logic [DATA_W-1:0] ma_oldest_price,
  input  logic [DATA_W-1:0] ma_avg,
  input  logic              ma_done,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              window_full,
  output logic              timeout_err
);

  localparam int PTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int CNT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  price_buf [WINDOW];
  logic               accept, done_hit, full_now;

`ifdef PRICE_FEEDER_TIMEOUT_EN
  logic [4:0] to_cnt;
  logic       timeout_hit;
`endif

  assign full_now    = (cnt == CNT_W'(WINDOW));
  assign price_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_hit  = 1'b0;
`ifdef PRICE_FEEDER_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: if (price_valid) begin
        accept    = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (ma_done) begin
          done_hit  = 1'b1;
          state_nxt = S_IDLE;
        end
`ifdef PRICE_FEEDER_TIMEOUT_EN
        // to_cnt==15 means this is the 16th WAIT cycle with no answer
        else if (to_cnt == 5'd15) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ring storage is never reset; cnt gating keeps stale slots from leaking out.
  always_ff @(posedge clk) begin
    if (!rst && accept) price_buf[wr_ptr] <= price_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      cnt             <= '0;
      ma_start        <= 1'b0;
      ma_new_price    <= '0;
      ma_oldest_price <= '0;
      avg_out         <= '0;
      avg_valid       <= 1'b0;
      window_full     <= 1'b0;
    end else begin
      ma_start  <= accept;
      avg_valid <= done_hit;
      if (accept) begin
        ma_new_price    <= price_in;
        ma_oldest_price <= full_now ? price_buf[wr_ptr] : '0;
        wr_ptr          <= (wr_ptr == PTR_W'(WINDOW - 1)) ? '0 : wr_ptr + PTR_W'(1);
        if (!full_now) cnt <= cnt + CNT_W'(1);
        window_full     <= full_now || (cnt == CNT_W'(WINDOW - 1));
      end
      if (done_hit) avg_out <= ma_avg;
    end
  end

`ifdef PRICE_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= (state == S_WAIT) ? to_cnt + 5'd1 : 5'd0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_price_window_feeder.sv
// Directed bench for price_window_feeder: vector table for the window fill
// and wrap, hand sequences for completion, reset abort and watchdog.
module tb_price_window_feeder;

  localparam int W = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] price_in;
  logic          price_valid;
  logic          price_ready;
  logic          ma_start;
  logic [DW-1:0] ma_new_price;
  logic [DW-1:0] ma_oldest_price;
  logic [DW-1:0] ma_avg;
  logic          ma_done;
  logic [DW-1:0] avg_out;
  logic          avg_valid;
  logic          window_full;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  price_window_feeder #(.WINDOW(W), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .price_in(price_in), .price_valid(price_valid), .price_ready(price_ready),
    .ma_start(ma_start), .ma_new_price(ma_new_price), .ma_oldest_price(ma_oldest_price),
    .ma_avg(ma_avg), .ma_done(ma_done),
    .avg_out(avg_out), .avg_valid(avg_valid),
    .window_full(window_full), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] price;
    logic [DW-1:0] avg;
    logic [DW-1:0] exp_old;
    logic          exp_full;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; price_valid = 1'b0; ma_done = 1'b0; price_in = '0; ma_avg = '0;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Accept one price, answer it from WAIT, check both halves of the handshake.
  task automatic txn(input logic [DW-1:0] p, input logic [DW-1:0] a,
                     input logic [DW-1:0] exp_old, input logic exp_full);
    price_in = p; price_valid = 1'b1;
    step();
    price_valid = 1'b0;
    chk("txn ma_start", ma_start, 1);
    chk("txn ma_new_price", ma_new_price, p);
    chk("txn ma_oldest_price", ma_oldest_price, exp_old);
    chk("txn window_full", window_full, exp_full);
    chk("txn ready_issue", price_ready, 0);
    step();
    chk("txn ma_start_drop", ma_start, 0);
    ma_avg = a; ma_done = 1'b1;
    step();
    ma_done = 1'b0;
    chk("txn avg_valid", avg_valid, 1);
    chk("txn avg_out", avg_out, a);
    chk("txn ready_idle", price_ready, 1);
    step();
    chk("txn avg_valid_drop", avg_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      tbl[i].price    = DW'(i + 1);
      tbl[i].avg      = DW'(3 * (i + 1));
      tbl[i].exp_old  = (i >= 10) ? DW'(i - 9) : '0;
      tbl[i].exp_full = (i >= 9);
    end

    // Scenario 1: reset values
    do_reset(2);
    chk("rst price_ready", price_ready, 1);
    chk("rst ma_start", ma_start, 0);
    chk("rst ma_new_price", ma_new_price, 0);
    chk("rst ma_oldest_price", ma_oldest_price, 0);
    chk("rst avg_out", avg_out, 0);
    chk("rst avg_valid", avg_valid, 0);
    chk("rst window_full", window_full, 0);
    chk("rst timeout_err", timeout_err, 0);

    // ma_done while IDLE must be ignored
    ma_avg = 32'd999; ma_done = 1'b1;
    step();
    ma_done = 1'b0;
    chk("idle done avg_valid", avg_valid, 0);
    chk("idle done avg_out", avg_out, 0);

    // Scenario 2: first sample; also ma_done in ISSUE is ignored
    price_in = 32'd100; price_valid = 1'b1;
    step();
    price_valid = 1'b0;
    chk("s2 ma_start", ma_start, 1);
    chk("s2 ma_new_price", ma_new_price, 100);
    chk("s2 ma_oldest_price", ma_oldest_price, 0);
    chk("s2 price_ready", price_ready, 0);
    ma_avg = 32'd7; ma_done = 1'b1;
    step();
    ma_done = 1'b0;
    chk("s2 issue done ignored", avg_valid, 0);
    chk("s2 still waiting", price_ready, 0);
    chk("s2 ma_start one cycle", ma_start, 0);
    ma_avg = 32'd8; ma_done = 1'b1;
    step();
    ma_done = 1'b0;
    chk("s2 avg_valid", avg_valid, 1);
    chk("s2 avg_out", avg_out, 8);

    // Scenario 3: fill and wrap
    do_reset(1);
    for (int i = 0; i < 12; i++)
      txn(tbl[i].price, tbl[i].avg, tbl[i].exp_old, tbl[i].exp_full);

    // Scenario 4: ma_done and price_valid together in WAIT
    price_in = 32'd13; price_valid = 1'b1;
    step();
    chk("s4 ma_new_price", ma_new_price, 13);
    chk("s4 ma_oldest_price", ma_oldest_price, 3);
    price_in = 32'd14;
    step();
    ma_avg = 32'd55; ma_done = 1'b1;
    step();
    ma_done = 1'b0;
    chk("s4 avg_valid", avg_valid, 1);
    chk("s4 avg_out", avg_out, 55);
    chk("s4 no accept in wait", ma_start, 0);
    chk("s4 new_price stable", ma_new_price, 13);
    chk("s4 ready", price_ready, 1);
    step();
    price_valid = 1'b0;
    chk("s4 avg_valid one cycle", avg_valid, 0);
    chk("s4 accept from idle", ma_start, 1);
    chk("s4 accepted price", ma_new_price, 14);
    chk("s4 oldest", ma_oldest_price, 4);
    chk("s4 avg_out held", avg_out, 55);
    step();
    ma_avg = 32'd1; ma_done = 1'b1;
    step();
    ma_done = 1'b0;
    step();

    // Scenario 5: reset in WAIT aborts the transaction
    do_reset(1);
    txn(32'd21, 32'd5, 32'd0, 1'b0);
    txn(32'd22, 32'd6, 32'd0, 1'b0);
    price_in = 32'd23; price_valid = 1'b1;
    step();
    price_valid = 1'b0;
    step();
    chk("s5 in wait", price_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5 ready after rst", price_ready, 1);
    chk("s5 new_price cleared", ma_new_price, 0);
    ma_avg = 32'd77; ma_done = 1'b1;
    step();
    ma_done = 1'b0;
    chk("s5 no avg_valid", avg_valid, 0);
    chk("s5 avg_out cleared", avg_out, 0);
    step();
    chk("s5 no avg_valid later", avg_valid, 0);
    txn(32'd31, 32'd9, 32'd0, 1'b0);

    // Scenario 6: withheld ma_done
    price_in = 32'd40; price_valid = 1'b1;
    step();
    price_valid = 1'b0;
    step();
`ifdef PRICE_FEEDER_TIMEOUT_EN
    repeat (15) step();
    chk("s6 not yet timed out", timeout_err, 0);
    chk("s6 still waiting", price_ready, 0);
    step();
    chk("s6 timeout_err", timeout_err, 1);
    chk("s6 ready after timeout", price_ready, 1);
    chk("s6 no avg_valid", avg_valid, 0);
    repeat (4) step();
    chk("s6 sticky", timeout_err, 1);
`else
    repeat (20) step();
    chk("s6 still waiting", price_ready, 0);
    chk("s6 timeout_err tied", timeout_err, 0);
    chk("s6 no avg_valid", avg_valid, 0);
`endif
    do_reset(1);
    chk("s6 rst clears timeout", timeout_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
